hamsi_msg_pad: RTL and testbench
================================

HAMSI_MSG_PAD -- requirements
Module: hamsi_msg_pad

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with all other ports listed below.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- init  input  1  start new message, one-cycle pulse
- load  input  1  idata valid, held high by host until ack
- final  input  1  end of message, one-cycle pulse
- idata  input  16  message half-word, big-endian
- ack  output  1  one-cycle acknowledge of an accepted half-word
- blk_data  output  32  padded message word to the Hamsi core
- blk_valid  output  1  blk_data valid
- blk_ready  input  1  core accepts blk_data
- blk_last  output  1  marks the final word (low length word)
- busy  output  1  message open or padding in progress
- err  output  1  sticky protocol error (see REQ-019)

Function
REQ-002 States SHALL be IDLE, COLLECT, PAD, LEN_HI, LEN_LO, DONE.
REQ-003 IDLE->COLLECT on init; in any state, init SHALL clear the half-word buffer, the 64-bit bit counter and blk_valid, then enter COLLECT.
REQ-004 A half-word SHALL be accepted at a rising edge when state=COLLECT, load=1, ack=0 and the output register is empty or is being drained that cycle (blk_valid=1 and blk_ready=1).
REQ-005 ack SHALL be high for exactly the cycle after each acceptance; if load is held continuously, half-words are accepted every second cycle.
REQ-006 Each acceptance SHALL add 16 to the bit counter, which wraps modulo 2^64.
REQ-007 The first half-word of a pair SHALL be held in the buffer; the second SHALL form blk_data={first,second} with blk_valid=1 one cycle after its acceptance.
REQ-008 blk_data, blk_valid and blk_last SHALL stay stable while blk_valid=1 and blk_ready=0; a word is transferred on a cycle where blk_valid=1 and blk_ready=1.
REQ-009 final in COLLECT SHALL enter PAD; if final and an acceptance occur in the same cycle, the half-word SHALL be taken first and counted in the length.
REQ-010 In PAD, once the output register is free, the block SHALL emit {buffer,16'h8000} if one half-word is pending, otherwise 32'h80000000, then go to LEN_HI.
REQ-011 LEN_HI SHALL emit bit_count[63:32], then go to LEN_LO.
REQ-012 LEN_LO SHALL emit bit_count[31:0] with blk_last=1, then go to DONE after the transfer.
REQ-013 DONE SHALL hold with blk_valid=0 until init.
REQ-014 busy SHALL be 1 in COLLECT, PAD, LEN_HI and LEN_LO, and also in DONE until the last word transfers; otherwise it SHALL be 0.
REQ-015 load SHALL be ignored outside COLLECT, and no ack SHALL be generated outside COLLECT.
REQ-016 final SHALL be ignored outside COLLECT.

Reset
REQ-017 On rst_n=0 the block SHALL asynchronously set state=IDLE, ack=0, blk_valid=0, blk_last=0, blk_data=0, busy=0, err=0, and clear the bit counter and buffer.
REQ-018 Reset mid-message SHALL discard all partial data; no word SHALL be emitted until the next init.

Configuration
REQ-019 With HAMSI_PAD_ERR_EN defined, err SHALL be set, and held until init or reset, by any of the following:
- load=1 in IDLE, PAD, LEN_HI, LEN_LO or DONE;
- final in a state other than COLLECT;
- bit counter wrap.
Without HAMSI_PAD_ERR_EN, err SHALL be tied to 0 and no error logic SHALL be built.

Verification
REQ-020 init, final, blk_ready=1 -> words 80000000, 00000000, 00000000 (blk_last=1).
REQ-021 init, load 6162, final -> ack once; words 61628000, 00000000, 00000010 (last).
REQ-022 init, load 6162, load 6364, final -> words 61626364, 80000000, 00000000, 00000020 (last).
REQ-023 Same as REQ-022 with blk_ready=0 for 5 cycles after each blk_valid rise -> no ack while the register is full; data held stable; identical word sequence.
REQ-024 load 1111 accepted, then rst_n pulsed low, then init, load 2222, load 3333, final -> words 22223333, 80000000, 00000000, 00000020 only.
REQ-025 With HAMSI_PAD_ERR_EN, load=1 in DONE -> err=1 and no ack; next init -> err=0.

Source files
------------

// File: rtl/hamsi_msg_pad.sv
// Hamsi message padder: packs 16-bit half-words into 32-bit words, then appends the 0x80 pad
// marker and the 64-bit big-endian bit length. Optional sticky error flag via HAMSI_PAD_ERR_EN.
module hamsi_msg_pad (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        load,
  // `final` is a reserved word, hence the suffix
  input  logic        final_i,
  input  logic [15:0] idata,
  output logic        ack,
  output logic [31:0] blk_data,
  output logic        blk_valid,
  input  logic        blk_ready,
  output logic        blk_last,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StPad,
    StLenHi,
    StLenLo,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic        ack_q, ack_d;
  logic [15:0] buf_q, buf_d;
  logic        half_q, half_d;
  logic [63:0] cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        out_free;
  logic        accept;

  // Output register can take a new word if empty or being drained this cycle
  assign out_free = !valid_q || blk_ready;
  assign accept   = (state_q == StCollect) && load && !ack_q && out_free && !init;

  always_comb begin
    state_d = state_q;
    ack_d   = accept;
    buf_d   = buf_q;
    half_d  = half_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;

    if (valid_q && blk_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end

    if (init) begin
      state_d = StCollect;
      buf_d   = '0;
      half_d  = 1'b0;
      cnt_d   = '0;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else begin
      case (state_q)
        StCollect: begin
          if (accept) begin
            cnt_d = cnt_q + 64'd16;
            if (half_q) begin
              data_d  = {buf_q, idata};
              valid_d = 1'b1;
              half_d  = 1'b0;
            end else begin
              buf_d  = idata;
              half_d = 1'b1;
            end
          end
          if (final_i) state_d = StPad;
        end
        StPad: begin
          if (out_free) begin
            data_d  = half_q ? {buf_q, 16'h8000} : 32'h8000_0000;
            valid_d = 1'b1;
            half_d  = 1'b0;
            state_d = StLenHi;
          end
        end
        StLenHi: begin
          if (out_free) begin
            data_d  = cnt_q[63:32];
            valid_d = 1'b1;
            state_d = StLenLo;
          end
        end
        StLenLo: begin
          if (out_free) begin
            data_d  = cnt_q[31:0];
            valid_d = 1'b1;
            last_d  = 1'b1;
            state_d = StDone;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ack_q   <= 1'b0;
      buf_q   <= '0;
      half_q  <= 1'b0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      buf_q   <= buf_d;
      half_q  <= half_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign ack       = ack_q;
  assign blk_data  = data_q;
  assign blk_valid = valid_q;
  assign blk_last  = last_q;
  // DONE stays busy until the low length word has actually left
  assign busy      = (state_q inside {StCollect, StPad, StLenHi, StLenLo}) ||
                     ((state_q == StDone) && valid_q);

`ifdef HAMSI_PAD_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (init) begin
      err_d = 1'b0;
    end else if ((load && (state_q != StCollect)) || (final_i && (state_q != StCollect)) ||
                 (accept && (&cnt_q[63:4]))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_hamsi_msg_pad.sv
// Bench for hamsi_msg_pad: directed and randomized messages compared against a padding model.
module tb_hamsi_msg_pad;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init, load, final_i, blk_ready;
  logic [15:0] idata;
  logic        ack, blk_valid, blk_last, busy, err;
  logic [31:0] blk_data;

  int checks = 0;
  int errors = 0;

  logic [15:0] msg_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  bit          got_last[$];

  hamsi_msg_pad dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .init     (init),
    .load     (load),
    .final_i  (final_i),
    .idata    (idata),
    .ack      (ack),
    .blk_data (blk_data),
    .blk_valid(blk_valid),
    .blk_ready(blk_ready),
    .blk_last (blk_last),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Reference: append 0x8000, pad to an even half-word count, then 64-bit bit length.
  function automatic void build_expected();
    logic [15:0] h[$];
    logic [63:0] bits;
    h = msg_q;
    bits = 64'(16 * msg_q.size());
    h.push_back(16'h8000);
    if (h.size() % 2 != 0) h.push_back(16'h0000);
    exp_q.delete();
    for (int i = 0; i < h.size(); i += 2) exp_q.push_back({h[i], h[i+1]});
    exp_q.push_back(bits[63:32]);
    exp_q.push_back(bits[31:0]);
  endfunction

  // mode 0: always ready, 1: ready low 5 cycles per new word, 2: random ready
  task automatic run_msg(input string name, input int mode, input bit fwl);
    int   idx = 0, cyc = 0, hold = 0, sz;
    bit   done = 0, fin_sent = 0, pred_acc = 0, prev_v = 0, prev_r = 0, prev_l = 0, new_word;
    logic [31:0] prev_d = '0;
    sz = msg_q.size();
    build_expected();
    got_q.delete();
    got_last.delete();
    @(negedge clk);
    init = 1; load = 0; final_i = 0; blk_ready = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      init = 0;
      final_i = 0;
      checks++;
      if (ack !== pred_acc) begin
        errors++;
        $display("FAIL %s ack: got %b exp %b (cycle %0d)", name, ack, pred_acc, cyc);
      end
      if (pred_acc) idx++;
      if (prev_v && !prev_r) begin
        checks++;
        if (blk_valid !== 1'b1 || blk_data !== prev_d || blk_last !== prev_l) begin
          errors++;
          $display("FAIL %s hold: got v%b %h l%b exp v1 %h l%b", name, blk_valid, blk_data,
                   blk_last, prev_d, prev_l);
        end
      end
      if (prev_v && prev_r) begin
        got_q.push_back(prev_d);
        got_last.push_back(prev_l);
        if (prev_l) done = 1;
      end
      checks++;
      if (busy !== !done) begin
        errors++;
        $display("FAIL %s busy: got %b exp %b", name, busy, !done);
      end
      if (done) begin
        load = 0;
        break;
      end
      new_word = blk_valid && !(prev_v && !prev_r);
      case (mode)
        0: blk_ready = 1'b1;
        1: begin
          if (new_word) hold = 5;
          blk_ready = (hold == 0);
          if (hold > 0) hold--;
        end
        default: blk_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (!fin_sent && idx < sz) begin
        load = 1;
        idata = msg_q[idx];
      end else begin
        load = 0;
        idata = 16'($urandom);
      end
      if (!fin_sent) begin
        if (idx == sz) begin
          final_i = 1; fin_sent = 1;
        end else if (fwl && idx == sz - 1 && !ack && (!blk_valid || blk_ready)) begin
          final_i = 1; fin_sent = 1;
        end
      end
      pred_acc = load && !ack && (!blk_valid || blk_ready);
      prev_v = blk_valid; prev_r = blk_ready; prev_d = blk_data; prev_l = blk_last;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: got %0d words exp %0d", name, got_q.size(), exp_q.size());
    end
    checks++;
    if (blk_valid !== 1'b0 || idx != sz) begin
      errors++;
      $display("FAIL %s end: got valid %b acks %0d exp valid 0 acks %0d", name, blk_valid,
               idx, sz);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s count: got %0d exp %0d", name, got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i] || got_last[i] !== (i == exp_q.size() - 1)) begin
          errors++;
          $display("FAIL %s word%0d: got %h last %b exp %h last %b", name, i, got_q[i],
                   got_last[i], exp_q[i], (i == exp_q.size() - 1));
        end
      end
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({ack, blk_valid, blk_last, busy, err} !== 5'b0 || blk_data !== 32'h0) begin
      errors++;
      $display("FAIL %s: got ack%b v%b l%b busy%b err%b data %h exp all zero", name, ack,
               blk_valid, blk_last, busy, err, blk_data);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; init = 0; load = 0; final_i = 0; blk_ready = 1; idata = 16'hFFFF;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1;
    load = 1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (ack !== 1'b0 || busy !== 1'b0 || blk_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_load: got ack%b busy%b v%b exp 0 0 0", ack, busy, blk_valid);
      end
    end
    load = 0;
  endtask

  task automatic test_directed();
    msg_q = {};                       run_msg("empty", 0, 0);
    msg_q = {16'h6162};               run_msg("one", 0, 0);
    msg_q = {16'h6162, 16'h6364};     run_msg("two", 0, 0);
    msg_q = {16'h6162, 16'h6364};     run_msg("backpressure", 1, 0);
    msg_q = {16'hA5A5, 16'h0001, 16'hBEEF}; run_msg("final_with_load", 0, 1);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    init = 1; load = 0;
    @(negedge clk);
    init = 0; load = 1; idata = 16'h1111;
    for (int i = 0; i < 20 && !ack; i++) @(negedge clk);
    checks++;
    if (ack !== 1'b1) begin
      errors++;
      $display("FAIL mid_ack: got %b exp 1", ack);
    end
    load = 0;
    rst_n = 0;
    #1;
    check_zero("mid_reset");
    @(negedge clk);
    rst_n = 1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (blk_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL post_reset: got v%b busy%b exp 0 0", blk_valid, busy);
      end
    end
    msg_q = {16'h2222, 16'h3333};
    run_msg("after_reset", 0, 0);
  endtask

  task automatic test_ignore_done();
    bit exp_err;
`ifdef HAMSI_PAD_ERR_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif
    load = 1; idata = 16'h5555;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (ack !== 1'b0 || blk_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL done_load: got ack%b v%b busy%b exp 0 0 0", ack, blk_valid, busy);
      end
    end
    load = 0; final_i = 1;
    @(negedge clk);
    final_i = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (blk_valid !== 1'b0 || busy !== 1'b0 || err !== exp_err) begin
      errors++;
      $display("FAIL done_final: got v%b busy%b err%b exp 0 0 %b", blk_valid, busy, err,
               exp_err);
    end
    init = 1;
    @(negedge clk);
    init = 0;
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reinit: got err%b busy%b exp 0 1", err, busy);
    end
  endtask

  task automatic test_random();
    for (int m = 0; m < 8; m++) begin
      int len;
      len = $urandom_range(0, 9);
      msg_q = {};
      for (int i = 0; i < len; i++) msg_q.push_back(16'($urandom));
      run_msg($sformatf("rand%0d", m), 2, bit'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_back_to_back();
    msg_q = {16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A};
    run_msg("b2b_a", 0, 0);
    msg_q = {16'hFFFF};
    run_msg("b2b_b", 1, 1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_done();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
